// File: rtl/bus_writeback_queue.sv
// bus_writeback_queue
//   Receiving end of the result bus. Bus results that target the register
//   file (sel 000..100) are queued in a circular buffer and written through
//   the register file write port whenever it is not taken by another writer
//   (rf_busy). Results from the regB store path (sel 101) are accepted and
//   dropped. Illegal selectors (110/111) are accepted, dropped, and flagged
//   with a one-cycle sel_err pulse. The queue also exports a pending-write
//   mask and youngest-entry forwarding so hazard logic can look inside it.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   bus result handshake (ready depends on count only)
//   in_data/in_sel/in_dest  bus value, source selector, destination register
//   rf_busy             write port taken by another writer this cycle
//   rf_we/rf_waddr/rf_wdata  register file write port (head of queue)
//   pending             bit r set while a queued entry targets register r
//   fwd_addr/fwd_hit/fwd_data  lookup of the youngest queued write to fwd_addr
//   sel_err             registered pulse after accepting sel 110/111
module bus_writeback_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [2:0]           in_sel,
  input  logic [ADDR_W-1:0]    in_dest,
  input  logic                 rf_busy,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pending,
  input  logic [ADDR_W-1:0]    fwd_addr,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data,
  output logic                 sel_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_t;

  occ_t               occ_state, occ_next;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [ADDR_W-1:0]  dest_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];

  logic               accept;
  logic               enq;
  logic               drain;
  logic               bad_sel;
  logic [PTR_W-1:0]   idx;

  // Handshake and occupancy next-state
  always_comb begin
    in_ready = (occ_state != FULL);
    accept   = in_valid & in_ready;
    // Only ALU, shift, imm, mem and pc results write the register file.
    enq      = accept & (in_sel <= 3'd4);
    bad_sel  = accept & (in_sel[2:1] == 2'b11);
    drain    = (occ_state != EMPTY) & ~rf_busy;

    cnt_next = cnt;
    case ({enq, drain})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase

    occ_next = PARTIAL;
    if (cnt_next == '0)
      occ_next = EMPTY;
    else if (cnt_next == CNT_W'(DEPTH))
      occ_next = FULL;
  end

  // State, pointers and entry storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_state <= EMPTY;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      sel_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      occ_state <= occ_next;
      cnt       <= cnt_next;
      sel_err   <= bad_sel;
      if (enq) begin
        dest_q[wr_ptr] <= in_dest;
        data_q[wr_ptr] <= in_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (drain)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write port: head entry is visible whenever the queue is non-empty
  always_comb begin
    rf_we    = drain;
    rf_waddr = '0;
    rf_wdata = '0;
    if (occ_state != EMPTY) begin
      rf_waddr = dest_q[rd_ptr];
      rf_wdata = data_q[rd_ptr];
    end
  end

  // Hazard view: walk from oldest to youngest so the last match is youngest.
  // The entry being accepted this cycle is not yet in storage, so it is
  // naturally excluded; the head being drained is still counted.
  always_comb begin
    pending  = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < cnt) begin
        pending[dest_q[idx]] = 1'b1;
        if (dest_q[idx] == fwd_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_writeback_queue.sv
module tb_bus_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic [3:0]  in_dest;
  logic        rf_busy;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] pending;
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic        sel_err;

  int checks = 0;
  int errors = 0;

  bus_writeback_queue #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_dest  (in_dest),
    .rf_busy  (rf_busy),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .pending  (pending),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic [15:0] x;
  } ent_t;

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [3:0]  dest;
    logic [15:0] data;
    logic        busy;
    logic [3:0]  faddr;
    logic        exp_ready;
    logic        exp_we;
  } vec_t;

  ent_t sb[$];
  logic exp_sel_err = 1'b0;
  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare all outputs against the queue model, step.
  // Called at posedge+2; compares at posedge+3.
  task automatic cycle(input logic v, input logic [2:0] sel, input logic [3:0] dest,
                       input logic [15:0] data, input logic busy, input logic [3:0] faddr,
                       input logic has_exp, input logic exp_ready, input logic exp_we);
    logic        ewe, eh, acc;
    logic [3:0]  ea;
    logic [15:0] ed, ep, ef;
    in_valid = v;
    in_sel   = sel;
    in_dest  = dest;
    in_data  = data;
    rf_busy  = busy;
    fwd_addr = faddr;
    #1;
    ewe = (sb.size() != 0) && !busy;
    ea  = (sb.size() != 0) ? sb[0].d : 4'd0;
    ed  = (sb.size() != 0) ? sb[0].x : 16'd0;
    ep  = '0;
    eh  = 1'b0;
    ef  = '0;
    foreach (sb[i]) begin
      ep[sb[i].d] = 1'b1;
      if (sb[i].d == faddr) begin
        eh = 1'b1;
        ef = sb[i].x;
      end
    end
    acc = v && (sb.size() < 4);
    chk("in_ready", in_ready, 32'(sb.size() < 4));
    chk("rf_we", rf_we, 32'(ewe));
    chk("rf_waddr", rf_waddr, 32'(ea));
    chk("rf_wdata", rf_wdata, 32'(ed));
    chk("pending", pending, 32'(ep));
    chk("fwd_hit", fwd_hit, 32'(eh));
    chk("fwd_data", fwd_data, 32'(ef));
    chk("sel_err", sel_err, 32'(exp_sel_err));
    if (has_exp) begin
      chk("tbl_ready", in_ready, 32'(exp_ready));
      chk("tbl_we", rf_we, 32'(exp_we));
    end
    @(posedge clk);
    if (ewe) void'(sb.pop_front());
    if (acc && sel <= 3'd4) sb.push_back('{d: dest, x: data});
    exp_sel_err = acc && (sel >= 3'd6);
    #2;
  endtask

  task automatic push(input logic [2:0] sel, input logic [3:0] dest, input logic [15:0] data,
                      input logic busy);
    cycle(1'b1, sel, dest, data, busy, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic busy, input logic [3:0] faddr);
    cycle(1'b0, 3'd0, 4'd0, 16'd0, busy, faddr, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // v, sel, dest, data, busy, faddr, exp_ready, exp_we
    tv[0]  = '{1'b1, 3'd0, 4'd3, 16'h1234, 1'b0, 4'd3, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 3'd0, 4'd0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1};
    tv[2]  = '{1'b0, 3'd0, 4'd0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 3'd0, 4'd1, 16'h0011, 1'b1, 4'd0, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 3'd1, 4'd2, 16'h0022, 1'b1, 4'd0, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 3'd2, 4'd3, 16'h0033, 1'b1, 4'd0, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 3'd3, 4'd4, 16'h0044, 1'b1, 4'd0, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 3'd4, 4'd5, 16'h0055, 1'b1, 4'd0, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 3'd0, 4'd0, 16'h0000, 1'b0, 4'd2, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 3'd0, 4'd0, 16'h0000, 1'b0, 4'd4, 1'b1, 1'b1};
    tv[10] = '{1'b0, 3'd0, 4'd0, 16'h0000, 1'b0, 4'd4, 1'b1, 1'b1};
    tv[11] = '{1'b0, 3'd0, 4'd0, 16'h0000, 1'b0, 4'd4, 1'b1, 1'b1};
    tv[12] = '{1'b0, 3'd0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_sel   = 3'd0;
    in_dest  = 4'd0;
    in_data  = 16'd0;
    rf_busy  = 1'b0;
    fwd_addr = 4'd0;
    #3;
    chk("rst_ready", in_ready, 32'd1);
    chk("rst_we", rf_we, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_sel_err", sel_err, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Single push then drain; a 4-deep fill under rf_busy, overflow ignored, drain
    for (int i = 0; i < 13; i++)
      cycle(tv[i].v, tv[i].sel, tv[i].dest, tv[i].data, tv[i].busy, tv[i].faddr,
            1'b1, tv[i].exp_ready, tv[i].exp_we);

    // Full + drain + in_valid in the same cycle must not accept; then wrap
    for (int i = 0; i < 4; i++)
      push(3'd0, 4'(6 + i), 16'(16'h0606 * (i + 1)), 1'b1);
    cycle(1'b1, 3'd0, 4'd15, 16'hDEAD, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      push(3'(i % 5), 4'(i), 16'hC000 + 16'(i), 1'b0);
    for (int i = 0; i < 5; i++)
      idle(1'b0, 4'd15);

    // Forwarding picks the youngest of two writes to the same register
    push(3'd0, 4'd5, 16'hAAAA, 1'b1);
    push(3'd1, 4'd5, 16'hBBBB, 1'b1);
    idle(1'b1, 4'd5);
    chk("fwd5_hit", fwd_hit, 32'd1);
    chk("fwd5_data", fwd_data, 32'h0000BBBB);
    fwd_addr = 4'd6;
    #1;
    chk("fwd6_hit", fwd_hit, 32'd0);
    chk("fwd6_data", fwd_data, 32'd0);
    #1;
    for (int i = 0; i < 3; i++)
      idle(1'b0, 4'd5);

    // regB store path and illegal selector: nothing queued, sel_err once
    push(3'd5, 4'd7, 16'h5555, 1'b0);
    chk("sel101_err", sel_err, 32'd0);
    push(3'd7, 4'd8, 16'h7777, 1'b0);
    chk("sel111_err", sel_err, 32'd1);
    idle(1'b0, 4'd7);
    chk("sel_err_gone", sel_err, 32'd0);
    idle(1'b0, 4'd8);

    // Asynchronous reset with writes queued and the port free
    for (int i = 0; i < 3; i++)
      push(3'd0, 4'(10 + i), 16'h0A00 + 16'(i), 1'b1);
    rf_busy  = 1'b0;
    in_valid = 1'b0;
    fwd_addr = 4'd10;
    #1;
    chk("pre_rst_we", rf_we, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_we", rf_we, 32'd0);
    chk("arst_waddr", rf_waddr, 32'd0);
    chk("arst_wdata", rf_wdata, 32'd0);
    chk("arst_pending", pending, 32'd0);
    chk("arst_fwd_hit", fwd_hit, 32'd0);
    chk("arst_fwd_data", fwd_data, 32'd0);
    chk("arst_ready", in_ready, 32'd1);
    sb.delete();
    exp_sel_err = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      idle(1'b0, 4'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
